// File: rtl/mod_113_pkg.sv
// Shared constants and state type for the word-serial mod-113 residue engine.
package mod_113_pkg;

   localparam int         WORD_W    = 16;
   localparam int         N_BEATS   = 25;
   localparam logic [6:0] MOD       = 7'd113;
   localparam logic [6:0] POW16     = 7'd109;
   localparam logic [6:0] POW7      = 7'd15;
   localparam logic [6:0] POW14     = 7'd112;
   localparam logic [4:0] LAST_BEAT = 5'd24;

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/mod_113_fold17.sv
// Combinational reduction of a 17-bit value to its residue mod 113.
module mod_113_fold17
   import mod_113_pkg::*;
(
   input  logic [17:1] v,
   output logic [7:1]  r
);

   logic [12:1] f1_s;
   logic [9:1]  f2_s;
   logic [8:1]  f3_s;

   // Weights: bit 8 is 2^7 == 15, bit 15 is 2^14 == 112; each refold shrinks the range.
   always_comb begin
      f1_s = 12'(v[7:1]) + 12'(v[14:8]) * 12'(POW7) + 12'(v[17:15]) * 12'(POW14);
      f2_s = 9'(f1_s[7:1]) + 9'(f1_s[12:8]) * 9'(POW7);
      f3_s = 8'(f2_s[7:1]) + 8'(f2_s[9:8]) * 8'(POW7);
      if (f3_s >= 8'(MOD)) begin
         r = 7'(f3_s - 8'(MOD));
      end else begin
         r = f3_s[7:1];
      end
   end

endmodule

// File: rtl/x_400_mod_113_serial.sv
// Accepts a 400-bit operand as 25 MSB-first 16-bit beats and returns X mod 113.
module x_400_mod_113_serial
   import mod_113_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [16:1] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:1]  R
);

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [7:1]  acc_q, acc_d;
   logic [7:1]  r_q, r_d;
   logic [17:1] sum_s;
   logic [7:1]  acc_next_s;

   // Horner step: 2^16 == 109 mod 113, so the running residue is scaled by 109.
   assign sum_s = 17'(acc_q) * 17'(POW16) + 17'(in_data);

   mod_113_fold17 u_fold (
      .v (sum_s),
      .r (acc_next_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      r_d     = r_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               if (cnt_q == LAST_BEAT) begin
                  r_d     = acc_next_s;
                  state_d = HOLD;
                  cnt_d   = 5'd0;
                  acc_d   = 7'd0;
               end else begin
                  cnt_d = cnt_q + 5'd1;
                  acc_d = acc_next_s;
               end
            end else begin
               state_d = LOAD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = LOAD;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         cnt_q   <= 5'd0;
         acc_q   <= 7'd0;
         r_q     <= 7'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         r_q     <= r_d;
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == HOLD);
   assign R         = r_q;

endmodule

// File: tb/tb_x_400_mod_113_serial.sv
// Directed bench for the serial mod-113 engine and its 17-bit fold stage.
module tb_x_400_mod_113_serial;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [16:1] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:1]  R;

   logic [17:1] fold_in;
   logic [7:1]  fold_out;

   int n_vec;
   int n_miss;
   int cyc;

   x_400_mod_113_serial dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R         (R)
   );

   mod_113_fold17 u_fold_chk (
      .v (fold_in),
      .r (fold_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model_mod(input logic [399:0] x);
      int r;
      r = 0;
      for (int k = 0; k < 25; k++) begin
         r = (r * 65536 + int'(x[399-16*k -: 16])) % 113;
      end
      return r;
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_vec("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   // Sends the first n_beats beats of x; out_valid must stay low until the 25th.
   task automatic send_op(input logic [399:0] x, input int n_beats, input bit gaps);
      for (int k = 0; k < n_beats; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               in_valid = 1'b0;
               @(negedge clk);
            end
         end
         wait_ready();
         in_valid = 1'b1;
         in_data  = x[399-16*k -: 16];
         @(negedge clk);
         if (k == 23) check_vec("early_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b0;
   endtask

   task automatic check_result(input string tag, input int exp);
      check_vec({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_vec({tag, "_ready"}, 32'(in_ready), 32'd0);
      check_vec({tag, "_R"}, 32'(R), 32'(exp));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_vec("rel_ready", 32'(in_ready), 32'd1);
      check_vec("rel_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [399:0] x;
      int           last_cyc;
      n_vec     = 0;
      n_miss    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;
      fold_in   = 17'd0;

      for (int v = 0; v < 131072; v++) begin
         fold_in = 17'(v);
         #1;
         check_vec("fold", 32'(fold_out), 32'(v % 113));
      end

      @(negedge clk);
      @(negedge clk);
      check_vec("rst_ready", 32'(in_ready), 32'd1);
      check_vec("rst_valid", 32'(out_valid), 32'd0);
      check_vec("rst_R", 32'(R), 32'd0);
      rst = 1'b0;

      send_op(400'd0, 25, 1'b0);
      check_result("zeros", 0);
      release_out();

      send_op(400'd113, 25, 1'b0);
      check_result("x113", 0);
      release_out();

      send_op(400'd1, 25, 1'b0);
      check_result("x1", 1);
      release_out();

      send_op(400'h1_0000, 25, 1'b0);
      check_result("x2p16", 109);
      release_out();

      send_op({400{1'b1}}, 25, 1'b0);
      check_result("ones", 29);
      release_out();

      send_op({400{1'b1}}, 25, 1'b1);
      check_result("ones_gap", 29);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_result("stall", 29);
      end
      in_valid = 1'b0;
      release_out();

      send_op(400'h1_0000, 25, 1'b1);
      check_result("after_stall", 109);
      release_out();

      send_op({400{1'b1}}, 12, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_vec("mid_rst_ready", 32'(in_ready), 32'd1);
      check_vec("mid_rst_valid", 32'(out_valid), 32'd0);
      check_vec("mid_rst_R", 32'(R), 32'd0);
      send_op(400'd0, 25, 1'b0);
      check_result("post_rst", 0);
      release_out();

      send_op(400'd1, 25, 1'b0);
      check_result("pre_hold_rst", 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_vec("hold_rst_ready", 32'(in_ready), 32'd1);
      check_vec("hold_rst_valid", 32'(out_valid), 32'd0);
      check_vec("hold_rst_R", 32'(R), 32'd0);

      out_ready = 1'b1;
      last_cyc  = 0;
      for (int n = 0; n < 1000; n++) begin
         x = 400'd0;
         for (int w = 0; w < 13; w++) begin
            x = {x[367:0], 32'($urandom)};
         end
         send_op(x, 25, 1'b0);
         check_result("rand", model_mod(x));
         if (n > 0) check_vec("period", 32'(cyc - last_cyc), 32'd26);
         last_cyc = cyc;
      end
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
